sub_bytes_engine: RTL
=====================

// Module: sub_bytes_engine
// PURPOSE
// - Forward AES SubBytes over a 128-bit state; the encrypt-side counterpart of Inv_S_Box.
// - Iterative: LANES forward S-box instances are reused over 16/LANES cycles.
// - Sits in the cipher round datapath between AddRoundKey and ShiftRows.
// - Valid/ready handshake on both sides.
// PARAMETERS
// - LANES   4   bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
// PORTS
// - clk        in   1    clock, all state updates on rising edge
// - rst        in   1    synchronous, active-high reset
// - in_valid   in   1    in_state is valid
// - in_ready   out  1    engine can accept a state
// - in_state   in   128  state to substitute; byte 0 = [127:120], byte 15 = [7:0]
// - out_valid  out  1    out_state holds a completed result
// - out_ready  in   1    downstream accepts the result
// - out_state  out  128  substituted state, same byte ordering
// - busy       out  1    high in RUN or DONE
// BEHAVIOUR
// - Reset (rst=1 at a clock edge):
//   - state = IDLE; in_ready=1; out_valid=0; busy=0; out_state=0; byte counter=0.
//   - Reset mid-RUN or mid-DONE discards the in-flight state; no output is produced.
// - FSM IDLE:
//   - in_ready=1.
//   - in_valid&in_ready: capture in_state into work reg, counter=0, go to RUN.
// - FSM RUN:
//   - in_ready=0.
//   - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work reg are replaced by S(byte).
//   - cnt increments; after the cycle with cnt = 16/LANES-1, go to DONE.
// - FSM DONE:
//   - out_valid=1; out_state = work reg, held stable while out_ready=0.
//   - out_valid&out_ready: go to IDLE.
// - Latency: accept edge -> out_valid high after exactly 16/LANES+1 edges (LANES=4: 5).
// - Throughput: one state per 16/LANES+2 cycles.
// - No input/output overlap: a new input is accepted only in IDLE, the cycle after the output handshake.
// - in_valid while in_ready=0 is ignored; the source holds its data (AXI-style).
// - out_ready while out_valid=0 has no effect.
// - S(x): GF(2^8) multiplicative inverse mod x^8+x^4+x^3+x+1 (0 maps to 0), then affine transform with constant 0x63.
//   - Combinational, no registers inside.
// - Counter width: $clog2(16/LANES), minimum 1 bit.
//   - Wraps to 0 on the RUN->DONE transition.
// STRUCTURE
// - Package aes_pkg:
//   - typedef logic [127:0] aes_state_t;
//   - typedef enum logic [1:0] {SB_IDLE, SB_RUN, SB_DONE} sb_state_e;
//   - localparam AES_POLY=8'h1B; localparam SBOX_AFFINE_C=8'h63.
// - One sub-module S_Box (8-bit A in, 8-bit B out), the forward mirror of Inv_S_Box.
//   - Instantiated LANES times via generate.
// - Top level holds the FSM, work register and byte-select mux/demux only.
// TESTING
// - S_Box exhaustive: A=00..FF -> B matches FIPS-197 table (00->63, 01->7C, 53->ED, FF->16).
//   - B fed into Inv_S_Box returns A for all 256 values.
// - FIPS-197 vector: in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=d42711aee0bf98f1b8b45de51e415230.
//   - With LANES=4, out_valid rises on the 5th edge after accept.
// - All-zero in_state -> 6363...63; all-FF in_state -> 1616...16.
//   - Repeat with LANES=1 (latency 17) and LANES=16 (latency 2).
// - Backpressure: hold out_ready=0 for 10 cycles in DONE.
//   - out_state stable, in_ready=0, a second in_valid is not accepted.
//   - Then out_ready=1 -> IDLE next cycle; second state accepted after that.
// - Reset mid-RUN: assert rst at cnt=2.
//   - Next cycle in_ready=1, out_valid=0, busy=0; no result emitted.
//   - A following vector completes correctly.
// - Back-to-back: in_valid and out_ready held high over 3 states.
//   - 3 correct results in order, spaced 16/LANES+2 cycles apart.

Source files
------------

// File: rtl/sub_bytes_engine_pkg.sv
// aes_pkg: shared AES state/FSM types, constants and GF(2^8) helpers
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef enum logic [1:0] {SB_IDLE, SB_RUN, SB_DONE} sb_state_e;
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, m;
    p = '0;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      p = m[0] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
      m = m >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction
  function automatic logic [7:0] sbox_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ SBOX_AFFINE_C;
  endfunction
endpackage

// File: rtl/sub_bytes_engine_s_box.sv
// S_Box: combinational forward AES S-box, inverse in GF(2^8) then affine map
module S_Box
  import aes_pkg::*;
(
  input  logic [7:0] A,
  output logic [7:0] B
);
  always_comb B = sbox_affine(gf_inv(A));
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes, LANES S-boxes reused over 16/LANES cycles
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);
  localparam int STEPS = 16 / LANES;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam int W = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  sb_state_e state_q, state_d;
  aes_state_t work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] base;
  logic [W-1:0] chunk, sub;
  assign base = 7'(127 - W * int'(cnt_q));
  assign chunk = work_q[base -: W];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    S_Box u_sbox (.A(chunk[8*g +: 8]), .B(sub[8*g +: 8]));
  end
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    cnt_d = cnt_q;
    case (state_q)
      SB_IDLE: begin
        work_d = in_valid ? in_state : work_q;
        cnt_d = in_valid ? '0 : cnt_q;
        state_d = in_valid ? SB_RUN : SB_IDLE;
      end
      SB_RUN: begin
        work_d[base -: W] = sub;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == LAST ? SB_DONE : SB_RUN;
      end
      SB_DONE: state_d = out_ready ? SB_IDLE : SB_DONE;
      default: state_d = SB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
      work_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == SB_IDLE;
  assign out_valid = state_q == SB_DONE;
  assign busy = state_q != SB_IDLE;
  assign out_state = work_q;
endmodule
